// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encoding and the
// elaboration-time clog2 helper used to size pointers and counters.
package fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, registered error pulses and selectable standard/FWFT read mode.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_WIDTH     = clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 wr_error_o,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 empty_o,
  output logic                 almost_empty_o,
  output logic                 rd_error_o,
  output logic [PTR_WIDTH:0]   count_o
);

  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL   = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_LVL  = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_LVL = CNT_WIDTH'(AEMPTY_THRESH);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_next;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;

  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic full_next;
  logic empty_next;
  logic almost_full_next;
  logic almost_empty_next;

  logic wr_error;
  logic rd_error;
  logic wr_accept;
  logic rd_accept;

  logic [WIDTH-1:0] mem_rdata;

  // Acceptance uses only the registered flags, i.e. the state before the edge.
  always_comb begin
    wr_accept   = wr_en_i & ~full;
    rd_accept   = rd_en_i & ~empty;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;

    if (wr_accept) begin
      wr_ptr_next = wr_ptr + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr + PTR_ONE;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Flags are derived from the next count so they register in step with it.
  always_comb begin
    full_next         = (count_next == CNT_FULL);
    empty_next        = (count_next == '0);
    almost_full_next  = (count_next >= AFULL_LVL);
    almost_empty_next = (count_next <= AEMPTY_LVL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_error     <= 1'b0;
      rd_error     <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      full         <= full_next;
      empty        <= empty_next;
      almost_full  <= almost_full_next;
      almost_empty <= almost_empty_next;
      wr_error     <= wr_en_i & full;
      rd_error     <= rd_en_i & empty;
    end
  end

  fifo_mem_2p #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (wr_accept & ~rst_i),
    .waddr (wr_ptr),
    .wdata (wdata_i),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
    // Head entry is presented directly; masked to zero while empty.
    assign rdata_o = empty ? '0 : mem_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_q <= '0;
      end else if (rd_accept) begin
        rdata_q <= mem_rdata;
      end
    end

    assign rdata_o = rdata_q;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = almost_full;
  assign almost_empty_o = almost_empty;
  assign wr_error_o     = wr_error;
  assign rd_error_o     = rd_error;
  assign count_o        = count;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: standard-mode and FWFT instances, DEPTH=8, WIDTH=8,
// AFULL_THRESH=6, AEMPTY_THRESH=2.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;
  logic       full, afull, wr_err, empty, aempty, rd_err;
  logic [7:0] rdata;
  logic [3:0] count;

  // FWFT instance
  logic       f_rst = 1'b1;
  logic       f_wr_en = 1'b0;
  logic [7:0] f_wdata = 8'h00;
  logic       f_rd_en = 1'b0;
  logic       f_full, f_afull, f_wr_err, f_empty, f_aempty, f_rd_err;
  logic [7:0] f_rdata;
  logic [3:0] f_count;

  int passed = 0;
  int total  = 0;

  sync_fifo_prog #(
    .WIDTH         (8),
    .DEPTH         (8),
    .AFULL_THRESH  (6),
    .AEMPTY_THRESH (2),
    .FWFT          (0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_en_i        (wr_en),
    .wdata_i        (wdata),
    .full_o         (full),
    .almost_full_o  (afull),
    .wr_error_o     (wr_err),
    .rd_en_i        (rd_en),
    .rdata_o        (rdata),
    .empty_o        (empty),
    .almost_empty_o (aempty),
    .rd_error_o     (rd_err),
    .count_o        (count)
  );

  sync_fifo_prog #(
    .WIDTH         (8),
    .DEPTH         (8),
    .AFULL_THRESH  (6),
    .AEMPTY_THRESH (2),
    .FWFT          (1)
  ) dut_fwft (
    .clk_i          (clk),
    .rst_i          (f_rst),
    .wr_en_i        (f_wr_en),
    .wdata_i        (f_wdata),
    .full_o         (f_full),
    .almost_full_o  (f_afull),
    .wr_error_o     (f_wr_err),
    .rd_en_i        (f_rd_en),
    .rdata_o        (f_rdata),
    .empty_o        (f_empty),
    .almost_empty_o (f_aempty),
    .rd_error_o     (f_rd_err),
    .count_o        (f_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_flags(input string tag, input int c);
    check({tag, ".count"},  32'(count),  32'(c));
    check({tag, ".empty"},  32'(empty),  32'(c == 0));
    check({tag, ".full"},   32'(full),   32'(c == 8));
    check({tag, ".aempty"}, 32'(aempty), 32'(c <= 2));
    check({tag, ".afull"},  32'(afull),  32'(c >= 6));
  endtask

  initial begin
    // Reset both instances
    tick();
    tick();
    rst   = 1'b0;
    f_rst = 1'b0;
    tick();
    check_flags("reset", 0);
    check("reset.rdata",   32'(rdata),    32'h00);
    check("reset.wr_err",  32'(wr_err),   32'd0);
    check("reset.rd_err",  32'(rd_err),   32'd0);
    check("reset.f_rdata", 32'(f_rdata),  32'h00);
    check("reset.f_empty", 32'(f_empty),  32'd1);

    // Write during reset is discarded
    rst = 1'b1; wr_en = 1'b1; wdata = 8'h33;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    check_flags("rst_wr", 0);
    check("rst_wr.wr_err", 32'(wr_err), 32'd0);
    tick();
    check("rst_wr.idle_count", 32'(count), 32'd0);

    // Fill with 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      tick();
      check_flags($sformatf("fill%0d", i), i);
      check($sformatf("fill%0d.wr_err", i), 32'(wr_err), 32'd0);
    end
    wr_en = 1'b0;

    // 9th write rejected
    wr_en = 1'b1; wdata = 8'h09;
    tick();
    wr_en = 1'b0;
    check("ovf.wr_err", 32'(wr_err), 32'd1);
    check_flags("ovf", 8);
    tick();
    check("ovf.wr_err_clear", 32'(wr_err), 32'd0);
    check("ovf.count_hold",   32'(count),  32'd8);

    // Drain, 1-cycle read latency
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      check($sformatf("drain%0d.rdata", i), 32'(rdata), 32'(i));
      check_flags($sformatf("drain%0d", i), 8 - i);
    end
    rd_en = 1'b0;

    // 9th read rejected, data holds
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf.rd_err", 32'(rd_err), 32'd1);
    check("udf.rdata",  32'(rdata),  32'h08);
    check_flags("udf", 0);
    tick();
    check("udf.rd_err_clear", 32'(rd_err), 32'd0);
    check("udf.rdata_hold",   32'(rdata),  32'h08);

    // Three rounds of 5 writes / 5 reads crossing the pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        wr_en = 1'b1; wdata = 8'(8'h10 + r * 5 + k);
        tick();
      end
      wr_en = 1'b0;
      check_flags($sformatf("wrap%0d.filled", r), 5);
      for (int k = 0; k < 5; k++) begin
        rd_en = 1'b1;
        tick();
        check($sformatf("wrap%0d.rd%0d", r, k), 32'(rdata), 32'(8'h10 + r * 5 + k));
      end
      rd_en = 1'b0;
      check_flags($sformatf("wrap%0d.drained", r), 0);
    end

    // Simultaneous wr+rd at full
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wdata = 8'(8'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    check_flags("sim_full.pre", 8);
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h99;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_flags("sim_full", 7);
    check("sim_full.wr_err", 32'(wr_err), 32'd1);
    check("sim_full.rd_err", 32'(rd_err), 32'd0);
    check("sim_full.rdata",  32'(rdata),  32'h20);
    for (int i = 1; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      check($sformatf("sim_full.drain%0d", i), 32'(rdata), 32'(8'h20 + i));
    end
    rd_en = 1'b0;
    check_flags("sim_full.drained", 0);

    // Simultaneous wr+rd at empty
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hAA;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_flags("sim_empty", 1);
    check("sim_empty.rd_err", 32'(rd_err), 32'd1);
    check("sim_empty.wr_err", 32'(wr_err), 32'd0);
    check("sim_empty.rdata",  32'(rdata),  32'h27);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("sim_empty.pop", 32'(rdata), 32'hAA);
    check_flags("sim_empty.after", 0);

    // Simultaneous wr+rd at count 4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wdata = 8'(8'hB0 + i);
      tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hB4;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_flags("sim_mid", 4);
    check("sim_mid.wr_err", 32'(wr_err), 32'd0);
    check("sim_mid.rd_err", 32'(rd_err), 32'd0);
    check("sim_mid.rdata",  32'(rdata),  32'hB0);
    for (int i = 1; i <= 4; i++) begin
      rd_en = 1'b1;
      tick();
      check($sformatf("sim_mid.drain%0d", i), 32'(rdata), 32'(8'hB0 + i));
    end
    rd_en = 1'b0;
    check_flags("sim_mid.drained", 0);

    // FWFT: first word falls through without rd_en
    f_wr_en = 1'b1; f_wdata = 8'h5A;
    tick();
    f_wr_en = 1'b0;
    check("fwft.rdata", 32'(f_rdata), 32'h5A);
    check("fwft.empty", 32'(f_empty), 32'd0);
    check("fwft.count", 32'(f_count), 32'd1);
    tick();
    check("fwft.rdata_idle", 32'(f_rdata), 32'h5A);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fwft.pop_empty", 32'(f_empty), 32'd1);
    check("fwft.pop_rdata", 32'(f_rdata), 32'h00);
    check("fwft.pop_count", 32'(f_count), 32'd0);

    // FWFT: two words, pop advances the head
    f_wr_en = 1'b1; f_wdata = 8'h11;
    tick();
    f_wdata = 8'h22;
    tick();
    f_wr_en = 1'b0;
    check("fwft2.head", 32'(f_rdata), 32'h11);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fwft2.next",  32'(f_rdata), 32'h22);
    check("fwft2.count", 32'(f_count), 32'd1);
    f_rd_en = 1'b1;
    tick();
    tick();
    f_rd_en = 1'b0;
    check("fwft2.rd_err", 32'(f_rd_err), 32'd1);
    check("fwft2.empty",  32'(f_empty),  32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Single-clock, parametrised FIFO. Next generation of the team's FIFO family.
- Generalises depth and width; pointer width is derived from DEPTH.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, and a selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Sits between single-clock-domain producers and consumers, e.g. packet staging and command queues.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; must be a power of 2, ≥2.
- PTR_WIDTH, $clog2(DEPTH), read/write pointer width; derived, never overridden.
- AFULL_THRESH, DEPTH-2, almost_full_o asserts when count ≥ this value (1..DEPTH).
- AEMPTY_THRESH, 2, almost_empty_o asserts when count ≤ this value (0..DEPTH-1).
- FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- wr_en_i  in  1  write request.
- wdata_i  in  WIDTH  write data.
- full_o  out  1  count == DEPTH.
- almost_full_o  out  1  count ≥ AFULL_THRESH.
- wr_error_o  out  1  one-cycle pulse: previous-cycle write was rejected because the FIFO was full.
- rd_en_i  in  1  read request (standard mode) or pop/acknowledge (FWFT mode).
- rdata_o  out  WIDTH  read data.
- empty_o  out  1  count == 0.
- almost_empty_o  out  1  count ≤ AEMPTY_THRESH.
- rd_error_o  out  1  one-cycle pulse: previous-cycle read was rejected because the FIFO was empty.
- count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, when rst_i is high at a clock edge:
  - wr_ptr = 0, rd_ptr = 0, count_o = 0.
  - empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0.
  - wr_error_o = 0, rd_error_o = 0, rdata_o = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data. It overrides any same-cycle wr_en_i/rd_en_i; no error pulses result.
- Acceptance is decided from the state before the edge:
  - A write is accepted iff wr_en_i & ~full_o. It stores wdata_i at mem[wr_ptr] and advances wr_ptr by 1.
  - A read is accepted iff rd_en_i & ~empty_o. It advances rd_ptr by 1.
- Pointers are PTR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0. Full/empty are determined only from count, never from pointer comparison.
- Count update per cycle:
  - +1 on write only; -1 on read only.
  - Unchanged on both or neither.
  - count_o, full_o, empty_o, almost_full_o and almost_empty_o are all registered and consistent with each other in every cycle.
- Simultaneous events:
  - Full with wr_en_i & rd_en_i: read accepted, write rejected (wr_error_o pulses). Count becomes DEPTH-1.
  - Empty with wr_en_i & rd_en_i: write accepted, read rejected (rd_error_o pulses). Count becomes 1. In standard mode rdata_o holds.
  - Neither full nor empty: both accepted; count unchanged.
- Errors: wr_error_o/rd_error_o are registered, high for exactly the cycle after the rejected request, and 0 otherwise. A rejected access changes no pointer, count or memory state.
- Standard mode (FWFT=0):
  - On an accepted read, rdata_o <= mem[rd_ptr] at the same edge, giving 1-cycle read latency.
  - rdata_o holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - rdata_o = mem[rd_ptr] combinationally whenever empty_o = 0.
  - rd_en_i pops the head entry.
  - rdata_o is 0 while empty_o = 1.
  - The first written word appears on rdata_o in the cycle after the write edge, together with empty_o deasserting.
- Threshold flags follow the registered count with no extra latency. Equality at the threshold asserts the flag.

Decomposition:
- Package fifo_pkg holds:
  - Mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
  - A clog2 helper, shared by all FIFOs in the family.
- Sub-module fifo_mem_2p: DEPTH x WIDTH register array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - Top level owns pointers, count, flags, errors and the read-mode muxing/registering.

Test Plan (DEPTH=8, WIDTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2):
- Reset, then idle:
  - Required: empty_o=1, almost_empty_o=1, full_o=0, count_o=0, rdata_o=0.
  - One wr_en_i with rst_i=1 leaves count_o=0.
- Write 0x01..0x08 on consecutive cycles:
  - Required: almost_empty_o deasserts when count reaches 3; almost_full_o asserts when count reaches 6; full_o=1 at count_o=8.
  - A 9th write (0x09) gives wr_error_o=1 for one cycle, and count stays 8.
- Standard mode, read 8 times:
  - Required: rdata_o = 0x01..0x08, each one cycle after its read; empty_o=1 after the 8th.
  - A 9th read gives rd_error_o=1 for one cycle, and rdata_o holds 0x08.
- Wrap-around: repeat 3 rounds of 5 writes then 5 reads with values 0x10 onward.
  - Required: data comes out in order across the pointer wrap, and count_o returns to 0 each round.
- Simultaneous events:
  - At full, wr+rd: count_o becomes 7, wr_error_o=1, head word read out.
  - At empty, wr+rd with 0xAA: count_o=1, rd_error_o=1.
  - At count 4, wr+rd: count_o stays 4, and no error is raised.
- FWFT=1: write 0x5A to the empty FIFO.
  - Required: the next cycle shows rdata_o=0x5A and empty_o=0 with no rd_en_i.
  - A pop then gives empty_o=1 and rdata_o=0.
